// File: rtl/md_unit_if.sv
// Bundle of the decoder/forwarding-side signals of the multiply/divide unit.
// The master is the pipeline side that issues operations and moves to HI/LO.
// The slave is the md_unit itself.
interface md_unit_if;
  logic        start;
  logic [1:0]  mdop;
  logic [31:0] a;
  logic [31:0] b;
  logic        we;
  logic        wsel;
  logic        rsel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] out;

  modport master (
    output start, mdop, a, b, we, wsel, rsel,
    input  busy, hi, lo, out
  );

  modport slave (
    input  start, mdop, a, b, we, wsel, rsel,
    output busy, hi, lo, out
  );
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit for the EX stage.
// The result is computed in the start cycle and parked in phi/plo. It is then
// committed to HI/LO after a fixed busy period, so the latency seen by the
// pipeline matches a multi-cycle multiplier/divider.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  md
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;
  logic [31:0] phi_q,   phi_d;
  logic [31:0] plo_q,   plo_d;

  logic signed [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a, abs_b;
  logic [31:0] num_u, den_u;
  logic [31:0] uq, ur;
  logic [31:0] sq, sr;
  logic [31:0] res_hi, res_lo;
  logic        div_by_zero;

  // Single-cycle result datapath; the signed divide runs on magnitudes so the
  // 0x80000000 / -1 case wraps cleanly to 0x80000000 with remainder 0.
  always_comb begin
    prod_s      = $signed({{32{md.a[31]}}, md.a}) * $signed({{32{md.b[31]}}, md.b});
    prod_u      = {32'd0, md.a} * {32'd0, md.b};
    abs_a       = md.a[31] ? (~md.a + 32'd1) : md.a;
    abs_b       = md.b[31] ? (~md.b + 32'd1) : md.b;
    div_by_zero = (md.b == 32'd0);
    // mdop[0] distinguishes the unsigned variants of both mult and div.
    num_u       = md.mdop[0] ? md.a : abs_a;
    den_u       = md.mdop[0] ? md.b : abs_b;
    if (div_by_zero) begin
      den_u = 32'd1;
    end
    uq = num_u / den_u;
    ur = num_u % den_u;
    // Quotient sign follows the operand signs; remainder follows the dividend.
    sq = (md.a[31] ^ md.b[31]) ? (~uq + 32'd1) : uq;
    sr = md.a[31] ? (~ur + 32'd1) : ur;
    case (md.mdop)
      2'd0:    {res_hi, res_lo} = prod_s;
      2'd1:    {res_hi, res_lo} = prod_u;
      2'd2:    {res_hi, res_lo} = div_by_zero ? {hi_q, lo_q} : {sr, sq};
      default: {res_hi, res_lo} = div_by_zero ? {hi_q, lo_q} : {ur, uq};
    endcase
  end

  // Next-state logic for the IDLE/RUN sequencer and the HI/LO registers.
  always_comb begin
    // NOTE: every target gets a default up front so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    case (state_q)
      ST_IDLE: begin
        if (md.we) begin
          if (md.wsel) hi_d = md.a;
          else         lo_d = md.a;
        end
        if (md.start) begin
          phi_d   = res_hi;
          plo_d   = res_lo;
          cnt_d   = md.mdop[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
          state_d = ST_RUN;
        end
      end
      default: begin
        // start/we are ignored here; the hazard unit never issues them.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State registers with synchronous reset that also drops any pending result.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  assign md.busy = (state_q == ST_RUN);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;
  assign md.out  = md.rsel ? hi_q : lo_q;

endmodule
